// File: rtl/pwm_decoder.sv
// pwm_decoder: measures period and 8-bit duty of an asynchronous PWM input; `PWM_DECODE_SLEEP_EN adds a sleep hold.
// Result lands 9 cycles after the synchronized rise (snapshot + 8-step divide); no backpressure, results overwrite.
module pwm_decoder #(
  parameter int               CNT_W   = 24,
  parameter logic [CNT_W-1:0] TIMEOUT = {CNT_W{1'b1}}
) (
  input  logic             clk_400K,
  input  logic             reset_n,
  input  logic             sleep,
  input  logic             pwm_in,
  output logic [7:0]       duty_out,
  output logic [CNT_W-1:0] period_out,
  output logic             meas_valid,
  output logic             stuck,
  output logic             overrun
);

  typedef enum logic [1:0] {ARM, MEASURE, DIVIDE} state_t;

  state_t           state;
  logic             s_meta, s, s_d;
  logic             rise;
  logic             sleep_hold;
  logic [CNT_W-1:0] per_cnt, hi_cnt;
  logic [CNT_W-1:0] p_snap;
  logic [CNT_W-1:0] rem;
  logic [6:0]       quo;
  logic [2:0]       iter;

  logic [CNT_W:0]   rem_sh;
  logic             q_bit;
  logic [CNT_W-1:0] rem_nxt;
  logic [7:0]       q_final;

`ifdef PWM_DECODE_SLEEP_EN
  assign sleep_hold = sleep;
`else
  logic sleep_unused;
  assign sleep_unused = sleep;
  assign sleep_hold   = 1'b0;
`endif

  assign rise = s & ~s_d;

  // One restoring-divide step; the remainder stays below P so CNT_W bits hold it.
  always_comb begin
    rem_sh  = {rem, 1'b0};
    q_bit   = (rem_sh >= {1'b0, p_snap});
    rem_nxt = q_bit ? (rem_sh[CNT_W-1:0] - p_snap) : rem_sh[CNT_W-1:0];
    q_final = (p_snap == '0) ? 8'hFF : {quo, q_bit};
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= TIMEOUT) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk_400K) begin
    if (!reset_n) begin
      s_meta     <= 1'b0;
      s          <= 1'b0;
      s_d        <= 1'b0;
      state      <= ARM;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      p_snap     <= '0;
      rem        <= '0;
      quo        <= '0;
      iter       <= '0;
      duty_out   <= '0;
      period_out <= '0;
      meas_valid <= 1'b0;
      stuck      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      s_meta     <= pwm_in;
      s          <= s_meta;
      s_d        <= s;
      meas_valid <= 1'b0;

      if (sleep_hold) begin
        state <= ARM;
      end else begin
        if (rise) begin
          per_cnt <= CNT_W'(1);
          hi_cnt  <= CNT_W'(1);
        end else if (state != ARM) begin
          per_cnt <= sat_inc(per_cnt);
          if (s) hi_cnt <= sat_inc(hi_cnt);
        end

        case (state)
          ARM: begin
            if (rise) state <= MEASURE;
          end
          MEASURE: begin
            if (!rise && per_cnt == TIMEOUT) begin
              stuck      <= 1'b1;
              duty_out   <= {8{s}};
              period_out <= '0;
              meas_valid <= 1'b1;
              state      <= ARM;
            end
          end
          DIVIDE: begin
            if (iter == 3'd7) begin
              duty_out   <= q_final;
              period_out <= p_snap;
              stuck      <= 1'b0;
              meas_valid <= 1'b1;
              state      <= MEASURE;
            end else begin
              rem  <= rem_nxt;
              quo  <= {quo[5:0], q_bit};
              iter <= iter + 3'd1;
            end
          end
          default: state <= ARM;
        endcase

        // A rise on the last divide step commits that result and starts the next,
        // so back-to-back 8-cycle periods measure without loss.
        if (rise && state != ARM) begin
          p_snap <= per_cnt;
          rem    <= hi_cnt;
          quo    <= '0;
          iter   <= '0;
          state  <= DIVIDE;
          if (state == DIVIDE && iter != 3'd7) overrun <= 1'b1;
        end
      end
    end
  end

endmodule
